// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte-in / data-register-read handshake between the serial receiver, the bus and the rx buffer
//   in_data/in_valid : received byte and its one-cycle strobe (receiver -> buffer)
//   rd_req           : decoded data-register read (bus -> buffer)
//   rd_data/rd_ack   : read result and one-cycle acknowledge (buffer -> bus)
interface uart_rx_fifo_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        rd_req;
  logic [31:0] rd_data;
  logic        rd_ack;
  modport master (output in_data, in_valid, rd_req, input rd_data, rd_ack);
  modport slave (input in_data, in_valid, rd_req, output rd_data, rd_ack);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte buffer behind the UART data register, with overflow, count, threshold irq and flush
//   bus_clk, bus_reset_l : clock, asynchronous active-low reset
//   bus                  : in_data/in_valid push side, rd_req/rd_data/rd_ack read side
//   flush, clr_overflow  : synchronous clear of contents, clear of the sticky overflow flag
//   overflow, count, irq : sticky drop flag, occupancy, registered level interrupt
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_THRESH = 1
) (
  input  logic                  bus_clk,
  input  logic                  bus_reset_l,
  uart_rx_fifo_if.slave         bus,
  input  logic                  flush,
  input  logic                  clr_overflow,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  irq
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(1 << DEPTH_LOG2);
  localparam logic [CW-1:0] THRESH = CW'(IRQ_THRESH);
  logic [7:0] mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic full, empty, pop, push, drop;
  logic [CW-1:0] next_count;
  // a pop frees a slot in the same edge, so a full buffer still accepts a byte when it is also being read
  always_comb begin
    full = count == FULL_CNT;
    empty = count == '0;
    pop = bus.rd_req && !empty && !flush;
    push = bus.in_valid && (!full || pop) && !flush;
    drop = bus.in_valid && full && !bus.rd_req && !flush;
    next_count = flush ? '0 : (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
  end
  always_ff @(posedge bus_clk)
    if (push) mem[wr_ptr] <= bus.in_data;
  always_ff @(posedge bus_clk or negedge bus_reset_l)
    if (!bus_reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      irq <= 1'b0;
      bus.rd_ack <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      wr_ptr <= flush ? '0 : push ? wr_ptr + DEPTH_LOG2'(1) : wr_ptr;
      rd_ptr <= flush ? '0 : pop ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
      count <= next_count;
      overflow <= drop || (overflow && !clr_overflow);
      irq <= (next_count >= THRESH) && !flush;
      bus.rd_ack <= bus.rd_req;
      bus.rd_data <= !bus.rd_req ? '0 : (empty || flush) ? '1 : {24'h0, mem[rd_ptr]};
    end
endmodule
